// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared types and helpers for the memory-bus initiator.
//   state_e : initiator FSM states (IDLE, WAIT, RESP)
//   clog2   : bit width needed to hold values 0..v-1 (minimum 1)
package mem_bus_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mem_bus_if.sv
// mem_bus_if: host command/response port plus register-bank strobe/done port.
//   master modport : view of the initiator (drives strobes and responses)
//   slave modport  : view of the host and register bank together
interface mem_bus_if #(
    parameter int AW = 16,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic          cmd_we;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rd;
    logic          mem_wr;
    logic [DW-1:0] mem_rdata;
    logic          mem_rd_done;
    logic          mem_wr_done;

    modport master (
        input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
               mem_rdata, mem_rd_done, mem_wr_done,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );

    modport slave (
        output cmd_valid, cmd_we, cmd_addr, cmd_wdata, rsp_ready,
               mem_rdata, mem_rd_done, mem_wr_done,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_addr, mem_wdata, mem_rd, mem_wr
    );

endinterface

// File: rtl/mem_bus_timeout.sv
// mem_bus_timeout: clearable up-counter flagging the last cycle of the wait window.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : restart the count at 0
//   en_i       : count one cycle
//   expired_o  : count has reached TIMEOUT-1
module mem_bus_timeout import mem_bus_pkg::*; #(
    parameter int TIMEOUT = 255,
    parameter int CW      = clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n || clr_i) cnt_q <= '0;
        else if (en_i)       cnt_q <= cnt_q + CW'(1);
    end

    assign expired_o = cnt_q == CW'(TIMEOUT - 1);

endmodule

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-command initiator toward a strobe/done register bank.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : mem_bus_if.master (cmd valid/ready in, rsp valid/ready out,
//                mem_addr/mem_wdata/mem_rd/mem_wr out, mem_rdata/done pulses in)
module mem_bus_master import mem_bus_pkg::*; #(
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_bus_if.master    bus
);

    state_e        state_q;
    logic          we_q;
    logic          mem_rd_q;
    logic          mem_wr_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rsp_rdata_q;
    logic          cmd_ready;
    logic          accept;
    logic          done;
    logic          expired;

    assign cmd_ready = rst_n && state_q == IDLE;
    assign accept    = bus.cmd_valid && cmd_ready;
    // Only the done pulse matching the latched direction counts.
    assign done      = we_q ? bus.mem_wr_done : bus.mem_rd_done;

    mem_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     (accept),
        .en_i      (state_q == WAIT),
        .expired_o (expired)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            we_q        <= 1'b0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            mem_rd_q <= 1'b0;
            mem_wr_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.cmd_valid) begin
                    mem_addr_q  <= bus.cmd_addr;
                    mem_wdata_q <= bus.cmd_wdata;
                    we_q        <= bus.cmd_we;
                    mem_wr_q    <= bus.cmd_we;
                    mem_rd_q    <= !bus.cmd_we;
                    state_q     <= WAIT;
                end
                // A done in the expiry cycle still wins over the timeout.
                WAIT: if (done || expired) begin
                    rsp_rdata_q <= (done && !we_q) ? bus.mem_rdata : '0;
                    rsp_err_q   <= !done;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: if (bus.rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;

endmodule

// File: doc/mem_bus_master.md
# mem_bus_master

Initiator for the Cheby-generated memory-mapped register-bank interface (address, read/write strobes, done pulses). It accepts single read or write commands over a valid/ready port and drives one strobe per command toward a register bank. It then waits for the matching done pulse, with a bounded timeout, and returns read data and an error flag over a valid/ready response port. It sits between a host-side controller (UART/PCIe bridge, test sequencer) and any generated register bank.

## Interface
Parameters:
- AW, 16: byte-address width of cmd_addr / mem_addr.
- DW, 32: data width.
- TIMEOUT, 255: cycles to wait for done after the strobe; range 1..65535.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE with rst_n high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  AW  byte address.
- cmd_wdata  in  DW  write data.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DW  read data; 0 for writes and for timeouts.
- rsp_err  out  1  1 = timeout.
- mem_addr  out  AW  registered address, stable from strobe until done or timeout.
- mem_wdata  out  DW  registered write data, stable over the same window.
- mem_rd  out  1  one-cycle read strobe.
- mem_wr  out  1  one-cycle write strobe.
- mem_rdata  in  DW  read data, valid in the cycle mem_rd_done is high.
- mem_rd_done  in  1  read completion pulse.
- mem_wr_done  in  1  write completion pulse.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: on cmd_valid && cmd_ready:
  - latch cmd_addr, cmd_wdata and cmd_we into mem_addr, mem_wdata and an internal we register;
  - register mem_wr = cmd_we and mem_rd = !cmd_we for the next cycle only;
  - clear the timeout counter; go to WAIT.
- WAIT: counter increments each cycle, starting at 0 in the strobe cycle.
  - The matching done (mem_rd_done if read, mem_wr_done if write) is accepted in any WAIT cycle, including the strobe cycle itself.
  - On a read, register rsp_rdata = mem_rdata; on a write, register rsp_rdata = 0. Set rsp_err = 0; go to RESP.
  - If no matching done arrives and counter == TIMEOUT-1: rsp_rdata = 0, rsp_err = 1; go to RESP.
  - Matching done and timeout in the same cycle: done wins, rsp_err = 0.
- A non-matching done pulse, or any done pulse outside WAIT, is ignored with no state change.
- RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready. On rsp_valid && rsp_ready go to IDLE. The next command is accepted no earlier than the following cycle.
- mem_addr and mem_wdata keep their last values in IDLE and RESP; they are not cleared.
- Reset (rst_n low, any state): state = IDLE; mem_rd, mem_wr, rsp_valid, rsp_err, cmd_ready = 0; rsp_rdata, mem_addr, mem_wdata, counter = 0. An in-flight transaction is abandoned and produces no response.

## Timing
- Command accepted at cycle T; strobe high at T+1 only; earliest response with rsp_valid high at T+2, when done arrives in T+1.
- With a responder whose done is registered one cycle after the strobe: done at T+2, rsp_valid at T+3 for both reads and writes.
- Timeout: no done → rsp_valid at T+1+TIMEOUT with rsp_err = 1.
- Throughput: at most one command per 3 cycles (IDLE, WAIT, RESP).
- Exactly one strobe per accepted command. mem_rd and mem_wr are never high together.

## Structure
- Shared package mem_bus_pkg:
  - state enum (IDLE, WAIT, RESP);
  - function clog2 for sizing the counter, width clog2(TIMEOUT+1).
- One natural sub-module: mem_bus_timeout, a loadable/clearable down- or up-counter with an expired flag. All other logic stays in mem_bus_master.

## Test plan
- Read, done at strobe+1 with mem_rdata = 0xCAFE0001 → single mem_rd pulse; rsp_valid 3 cycles after accept; rsp_rdata = 0xCAFE0001; rsp_err = 0.
- Write addr 0x0004, data 0x000007FF, done in the strobe cycle → single mem_wr pulse; mem_wdata = 0x7FF; rsp_valid at accept+2; rsp_rdata = 0; rsp_err = 0.
- TIMEOUT=8, no done → rsp_err = 1 and rsp_rdata = 0 exactly 9 cycles after accept; a done arriving later is ignored.
- Done on the last timeout cycle → rsp_err = 0. Non-matching mem_wr_done during a read → ignored; read completes normally on mem_rd_done.
- rsp_ready held low for 5 cycles → rsp_valid, rsp_rdata and rsp_err stable; cmd_ready = 0; a cmd_valid presented meanwhile is accepted only after the handshake.
- rst_n low for 1 cycle during WAIT → no response; all outputs 0; cmd_ready = 1 the cycle after release; a back-to-back command then completes normally.
